// File: rtl/interrupt_sequencer_if.sv
// Bus and control bundle between the interrupt sequencer and the CPU datapath.
// The master side is the sequencer: it samples the request/status inputs and
// drives the bus, stack and PC-load controls while it owns the datapath.
interface interrupt_sequencer_if;
   logic        clk_enable;
   logic        irq;
   logic        nmi;
   logic        i_flag;
   logic        instr_boundary;
   logic [15:0] pc_in;
   logic [7:0]  sp_in;
   logic [7:0]  status_in;
   logic [7:0]  data_in;
   logic        busy;
   logic [15:0] address;
   logic        rw;
   logic [7:0]  data_out;
   logic        sp_dec;
   logic        pc_load;
   logic [15:0] pc_value;
   logic        set_i;
   logic [1:0]  source;

   modport master (
      input  clk_enable, irq, nmi, i_flag, instr_boundary,
             pc_in, sp_in, status_in, data_in,
      output busy, address, rw, data_out, sp_dec, pc_load, pc_value, set_i, source
   );

   modport slave (
      output clk_enable, irq, nmi, i_flag, instr_boundary,
             pc_in, sp_in, status_in, data_in,
      input  busy, address, rw, data_out, sp_dec, pc_load, pc_value, set_i, source
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ entry sequencer: pushes PCH, PCL, P, fetches the vector, loads PC, sets I.
// Latency: reset takes 3 enabled busy cycles after S_RST; an interrupt takes 6 busy cycles.
// Backpressure: clk_enable=0 freezes state, registers and all Moore outputs.
module interrupt_sequencer #(
   parameter logic [15:0] NMI_VECTOR   = 16'hFFFA,
   parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
   parameter logic [15:0] IRQ_VECTOR   = 16'hFFFE,
   parameter logic [7:0]  STACK_PAGE   = 8'h01
) (
   input logic                   clk,
   input logic                   rst_n,
   interrupt_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_RST,
      S_IDLE,
      S_PUSH_PCH,
      S_PUSH_PCL,
      S_PUSH_P,
      S_VEC_LO,
      S_VEC_HI,
      S_LOAD_PC
   } state_t;

   localparam logic [1:0] SRC_NONE  = 2'b00;
   localparam logic [1:0] SRC_RESET = 2'b01;
   localparam logic [1:0] SRC_NMI   = 2'b10;
   localparam logic [1:0] SRC_IRQ   = 2'b11;

   state_t      state_q, state_d;
   logic [1:0]  source_q, source_d;
   logic        nmi_prev_q, nmi_prev_d;
   logic        nmi_pending_q, nmi_pending_d;
   logic [7:0]  sp_lat_q, sp_lat_d;
   logic [15:0] pc_lat_q, pc_lat_d;
   logic [7:0]  p_lat_q, p_lat_d;
   logic [7:0]  vec_lo_q, vec_lo_d;
   logic [7:0]  vec_hi_q, vec_hi_d;

   logic        nmi_edge;
   logic        nmi_take;
   logic        irq_take;
   logic [15:0] vec_base;
   logic [7:0]  sp_m1;
   logic [7:0]  sp_m2;

   logic        busy_o;
   logic [15:0] address_o;
   logic        rw_o;
   logic [7:0]  data_out_o;
   logic        sp_dec_o;
   logic        pc_load_o;
   logic [15:0] pc_value_o;
   logic        set_i_o;

   // Vector base follows the latched source so no separate register is needed.
   always_comb begin
      case (source_q)
         SRC_NMI: vec_base = NMI_VECTOR;
         SRC_IRQ: vec_base = IRQ_VECTOR;
         default: vec_base = RESET_VECTOR;
      endcase
   end

   assign sp_m1 = sp_lat_q - 8'd1;
   assign sp_m2 = sp_lat_q - 8'd2;

   // Next-state logic, NMI edge tracking and entry latches.
   always_comb begin
      state_d       = state_q;
      source_d      = source_q;
      nmi_prev_d    = bus.nmi;
      nmi_edge      = bus.nmi & ~nmi_prev_q;
      nmi_pending_d = nmi_pending_q | nmi_edge;
      sp_lat_d      = sp_lat_q;
      pc_lat_d      = pc_lat_q;
      p_lat_d       = p_lat_q;
      vec_lo_d      = vec_lo_q;
      vec_hi_d      = vec_hi_q;
      // An edge arriving in the boundary cycle itself is honoured at once so
      // that a simultaneous NMI and IRQ resolve to NMI.
      nmi_take      = bus.instr_boundary & (nmi_pending_q | nmi_edge);
      irq_take      = bus.instr_boundary & bus.irq & ~bus.i_flag;

      case (state_q)
         S_RST: begin
            source_d = SRC_RESET;
            state_d  = S_VEC_LO;
         end
         S_IDLE: begin
            if (nmi_take || irq_take) begin
               sp_lat_d = bus.sp_in;
               pc_lat_d = bus.pc_in;
               p_lat_d  = bus.status_in;
               state_d  = S_PUSH_PCH;
               if (nmi_take) begin
                  source_d = SRC_NMI;
                  // The consumed request clears; a second edge on top of an
                  // already pending one stays pending.
                  nmi_pending_d = nmi_pending_q & nmi_edge;
               end else begin
                  source_d = SRC_IRQ;
               end
            end
         end
         S_PUSH_PCH: state_d = S_PUSH_PCL;
         S_PUSH_PCL: state_d = S_PUSH_P;
         S_PUSH_P:   state_d = S_VEC_LO;
         S_VEC_LO: begin
            vec_lo_d = bus.data_in;
            state_d  = S_VEC_HI;
         end
         S_VEC_HI: begin
            vec_hi_d = bus.data_in;
            state_d  = S_LOAD_PC;
         end
         S_LOAD_PC: begin
            source_d = SRC_NONE;
            state_d  = S_IDLE;
         end
         default: state_d = S_RST;
      endcase
   end

   // State and register update, gated by clk_enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RST;
         source_q      <= SRC_RESET;
         nmi_prev_q    <= 1'b0;
         nmi_pending_q <= 1'b0;
         sp_lat_q      <= 8'h00;
         pc_lat_q      <= 16'h0000;
         p_lat_q       <= 8'h00;
         vec_lo_q      <= 8'h00;
         vec_hi_q      <= 8'h00;
      end else if (bus.clk_enable) begin
         state_q       <= state_d;
         source_q      <= source_d;
         nmi_prev_q    <= nmi_prev_d;
         nmi_pending_q <= nmi_pending_d;
         sp_lat_q      <= sp_lat_d;
         pc_lat_q      <= pc_lat_d;
         p_lat_q       <= p_lat_d;
         vec_lo_q      <= vec_lo_d;
         vec_hi_q      <= vec_hi_d;
      end
   end

   // Moore output decode from state and latched registers.
   always_comb begin
      busy_o     = 1'b1;
      address_o  = 16'h0000;
      rw_o       = 1'b1;
      data_out_o = 8'h00;
      sp_dec_o   = 1'b0;
      pc_load_o  = 1'b0;
      pc_value_o = 16'h0000;
      set_i_o    = 1'b0;
      case (state_q)
         S_IDLE: busy_o = 1'b0;
         S_PUSH_PCH: begin
            address_o  = {STACK_PAGE, sp_lat_q};
            rw_o       = 1'b0;
            data_out_o = pc_lat_q[15:8];
            sp_dec_o   = 1'b1;
         end
         S_PUSH_PCL: begin
            address_o  = {STACK_PAGE, sp_m1};
            rw_o       = 1'b0;
            data_out_o = pc_lat_q[7:0];
            sp_dec_o   = 1'b1;
         end
         S_PUSH_P: begin
            // Pushed P always has bit 5 set and B (bit 4) clear.
            address_o  = {STACK_PAGE, sp_m2};
            rw_o       = 1'b0;
            data_out_o = (p_lat_q | 8'h20) & ~8'h10;
            sp_dec_o   = 1'b1;
         end
         S_VEC_LO: address_o = vec_base;
         S_VEC_HI: address_o = vec_base + 16'd1;
         S_LOAD_PC: begin
            pc_load_o  = 1'b1;
            pc_value_o = {vec_hi_q, vec_lo_q};
            set_i_o    = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy     = busy_o;
   assign bus.address  = address_o;
   assign bus.rw       = rw_o;
   assign bus.data_out = data_out_o;
   assign bus.sp_dec   = sp_dec_o;
   assign bus.pc_load  = pc_load_o;
   assign bus.pc_value = pc_value_o;
   assign bus.set_i    = set_i_o;
   assign bus.source   = source_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: memory model, bus-cycle log and transaction-level
// expectations built from the reset/interrupt entry rules.
// Each scenario task drives stimulus and compares the logged busy cycles.
module tb_interrupt_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   interrupt_sequencer_if sif();

   interrupt_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   typedef struct packed {
      logic        busy;
      logic [15:0] addr;
      logic [7:0]  dat;
      logic        rw;
      logic        sp_dec;
      logic        pc_load;
      logic [15:0] pc_value;
      logic        set_i;
      logic [1:0]  src;
   } cyc_t;

   logic [7:0] mem [0:65535];
   cyc_t       now_c;
   cyc_t       log_q[$];
   cyc_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   assign sif.data_in = mem[sif.address];

   always_comb begin
      now_c.busy     = sif.busy;
      now_c.addr     = sif.address;
      now_c.dat      = sif.data_out;
      now_c.rw       = sif.rw;
      now_c.sp_dec   = sif.sp_dec;
      now_c.pc_load  = sif.pc_load;
      now_c.pc_value = sif.pc_value;
      now_c.set_i    = sif.set_i;
      now_c.src      = sif.source;
   end

   // Record every enabled busy cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n && sif.clk_enable && sif.busy) log_q.push_back(now_c);
   end

   function automatic cyc_t mk(input logic [15:0] a, input logic [7:0] d, input logic rw,
                               input logic spd, input logic pl, input logic [15:0] pv,
                               input logic si, input logic [1:0] src);
      cyc_t c;
      c.busy = 1'b1; c.addr = a; c.dat = d; c.rw = rw; c.sp_dec = spd;
      c.pc_load = pl; c.pc_value = pv; c.set_i = si; c.src = src;
      return c;
   endfunction

   // Expected bus cycles of an interrupt entry: three stack writes, two vector reads, PC load.
   function automatic void exp_int(input logic [1:0] src, input logic [15:0] pc,
                                   input logic [7:0] sp, input logic [7:0] p);
      logic [15:0] vb;
      logic [7:0]  s1, s2, pp;
      vb = (src == 2'b10) ? 16'hFFFA : 16'hFFFE;
      s1 = sp - 8'd1;
      s2 = sp - 8'd2;
      pp = (p | 8'h20) & 8'hEF;
      exp_q.delete();
      exp_q.push_back(mk({8'h01, sp}, pc[15:8], 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, src));
      exp_q.push_back(mk({8'h01, s1}, pc[7:0],  1'b0, 1'b1, 1'b0, 16'h0, 1'b0, src));
      exp_q.push_back(mk({8'h01, s2}, pp,       1'b0, 1'b1, 1'b0, 16'h0, 1'b0, src));
      exp_q.push_back(mk(vb,          8'h00,    1'b1, 1'b0, 1'b0, 16'h0, 1'b0, src));
      exp_q.push_back(mk(vb + 16'd1,  8'h00,    1'b1, 1'b0, 1'b0, 16'h0, 1'b0, src));
      exp_q.push_back(mk(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1,
                         {mem[vb + 16'd1], mem[vb]}, 1'b1, src));
   endfunction

   // Expected cycles after reset release: S_RST cycle, vector reads, PC load; no pushes.
   function automatic void exp_reset();
      exp_q.delete();
      exp_q.push_back(mk(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b01));
      exp_q.push_back(mk(16'hFFFC, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b01));
      exp_q.push_back(mk(16'hFFFD, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b01));
      exp_q.push_back(mk(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1,
                         {mem[16'hFFFD], mem[16'hFFFC]}, 1'b1, 2'b01));
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      cyc_t rs, got;
      int   st;
      rs = mk(16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b01);
      tick(2);
      n_checks++;
      if (now_c !== rs) begin
         n_fail++; $display("FAIL reset_outputs got %h exp %h", now_c, rs);
      end
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h80;
      st = log_q.size();
      rst_n = 1'b1;
      tick(6);
      exp_reset();
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL reset_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL reset_seq[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
      n_checks++;
      if (sif.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle busy got %b exp 0", sif.busy);
      end
   endtask

   task automatic test_irq_basic();
      cyc_t got;
      int   st;
      mem[16'hFFFE] = 8'h00;
      mem[16'hFFFF] = 8'h90;
      sif.pc_in = 16'h1234; sif.sp_in = 8'hFD; sif.status_in = 8'h31;
      sif.i_flag = 1'b0; sif.irq = 1'b1; sif.instr_boundary = 1'b1;
      st = log_q.size();
      tick(1);
      sif.instr_boundary = 1'b0; sif.irq = 1'b0;
      tick(7);
      exp_int(2'b11, 16'h1234, 8'hFD, 8'h31);
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL irq_basic_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL irq_basic[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
      n_checks++;
      if (sif.busy !== 1'b0 || sif.source !== 2'b00) begin
         n_fail++; $display("FAIL irq_basic_idle busy/src got %b/%b exp 0/00", sif.busy, sif.source);
      end
   endtask

   task automatic test_irq_random();
      cyc_t        got;
      int          st;
      logic [15:0] pc;
      logic [7:0]  sp, p;
      for (int k = 0; k < 4; k++) begin
         pc = 16'($urandom); sp = 8'($urandom); p = 8'($urandom);
         mem[16'hFFFE] = 8'($urandom);
         mem[16'hFFFF] = 8'($urandom);
         sif.pc_in = pc; sif.sp_in = sp; sif.status_in = p;
         sif.i_flag = 1'b0; sif.irq = 1'b1; sif.instr_boundary = 1'b0;
         st = log_q.size();
         tick($urandom_range(1, 3));
         n_checks++;
         if (log_q.size() != st || sif.busy !== 1'b0) begin
            n_fail++; $display("FAIL irq_rand_no_boundary[%0d] busy got %b exp 0", k, sif.busy);
         end
         sif.instr_boundary = 1'b1;
         tick(1);
         sif.instr_boundary = 1'b0; sif.irq = 1'b0;
         sif.pc_in = 16'($urandom); sif.sp_in = 8'($urandom); sif.status_in = 8'($urandom);
         tick(7);
         exp_int(2'b11, pc, sp, p);
         n_checks++;
         if (log_q.size() - st != exp_q.size()) begin
            n_fail++; $display("FAIL irq_rand_len[%0d] got %0d exp %0d", k, log_q.size() - st, exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            got = (st + i < log_q.size()) ? log_q[st + i] : '0;
            n_checks++;
            if (got !== exp_q[i]) begin
               n_fail++; $display("FAIL irq_rand[%0d][%0d] got %h exp %h", k, i, got, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_irq_masked();
      int st;
      st = log_q.size();
      sif.i_flag = 1'b1; sif.irq = 1'b1; sif.instr_boundary = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         n_checks++;
         if (sif.busy !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked[%0d] busy got %b exp 0", i, sif.busy);
         end
      end
      // Request withdrawn before any boundary is never taken.
      sif.i_flag = 1'b0; sif.instr_boundary = 1'b0;
      tick(3);
      sif.irq = 1'b0; sif.instr_boundary = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_checks++;
         if (sif.busy !== 1'b0) begin
            n_fail++; $display("FAIL irq_dropped[%0d] busy got %b exp 0", i, sif.busy);
         end
      end
      sif.instr_boundary = 1'b0;
      n_checks++;
      if (log_q.size() != st) begin
         n_fail++; $display("FAIL irq_masked_cycles got %0d exp 0", log_q.size() - st);
      end
   endtask

   task automatic test_nmi_priority();
      cyc_t        got;
      int          st;
      logic [15:0] pc;
      logic [7:0]  sp, p;
      mem[16'hFFFA] = 8'($urandom);
      mem[16'hFFFB] = 8'($urandom);
      mem[16'hFFFE] = 8'h11;
      mem[16'hFFFF] = 8'h22;
      pc = 16'($urandom); sp = 8'($urandom); p = 8'($urandom);
      sif.pc_in = pc; sif.sp_in = sp; sif.status_in = p;
      sif.i_flag = 1'b0; sif.irq = 1'b1; sif.nmi = 1'b1; sif.instr_boundary = 1'b1;
      st = log_q.size();
      tick(6);
      sif.i_flag = 1'b1;   // I set by the set_i pulse of the entry
      tick(5);
      exp_int(2'b10, pc, sp, p);
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL nmi_prio_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL nmi_prio[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
      // A fresh low->high pulse is taken at the (still asserted) boundary.
      sif.nmi = 1'b0;
      tick(1);
      pc = 16'($urandom); sp = 8'($urandom); p = 8'($urandom);
      sif.pc_in = pc; sif.sp_in = sp; sif.status_in = p;
      sif.nmi = 1'b1;
      st = log_q.size();
      tick(1);
      sif.instr_boundary = 1'b0; sif.irq = 1'b0; sif.nmi = 1'b0;
      tick(7);
      exp_int(2'b10, pc, sp, p);
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL nmi_second_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL nmi_second[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
      sif.i_flag = 1'b0;
   endtask

   task automatic test_sp_wrap();
      cyc_t        got;
      int          st;
      logic [15:0] pc;
      logic [7:0]  p;
      pc = 16'($urandom); p = 8'($urandom);
      mem[16'hFFFA] = 8'($urandom);
      mem[16'hFFFB] = 8'($urandom);
      sif.pc_in = pc; sif.sp_in = 8'h01; sif.status_in = p;
      sif.i_flag = 1'b0; sif.irq = 1'b0; sif.instr_boundary = 1'b0;
      st = log_q.size();
      sif.nmi = 1'b1;
      tick(1);
      sif.nmi = 1'b0;
      tick(1);
      n_checks++;
      if (sif.busy !== 1'b0) begin
         n_fail++; $display("FAIL nmi_pending_wait busy got %b exp 0", sif.busy);
      end
      sif.instr_boundary = 1'b1;
      tick(1);
      sif.instr_boundary = 1'b0;
      tick(7);
      exp_int(2'b10, pc, 8'h01, p);
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL sp_wrap_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL sp_wrap[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_clk_enable_freeze();
      cyc_t        got;
      int          st;
      logic [15:0] pc;
      logic [7:0]  sp, p;
      pc = 16'($urandom); sp = 8'($urandom); p = 8'($urandom);
      mem[16'hFFFE] = 8'($urandom);
      mem[16'hFFFF] = 8'($urandom);
      exp_int(2'b11, pc, sp, p);
      sif.pc_in = pc; sif.sp_in = sp; sif.status_in = p;
      sif.i_flag = 1'b0; sif.irq = 1'b1; sif.instr_boundary = 1'b1;
      st = log_q.size();
      tick(1);
      sif.instr_boundary = 1'b0; sif.irq = 1'b0;
      tick(1);
      sif.clk_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_checks++;
         if (now_c !== exp_q[1]) begin
            n_fail++; $display("FAIL freeze_pcl[%0d] got %h exp %h", i, now_c, exp_q[1]);
         end
      end
      sif.clk_enable = 1'b1;
      tick(7);
      n_checks++;
      if (log_q.size() - st != exp_q.size()) begin
         n_fail++; $display("FAIL freeze_len got %0d exp %0d", log_q.size() - st, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL freeze_seq[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      cyc_t        got, rs;
      int          st, st2;
      logic [15:0] pc;
      logic [7:0]  sp, p;
      rs = mk(16'h0, 8'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 2'b01);
      pc = 16'($urandom); sp = 8'($urandom); p = 8'($urandom);
      mem[16'hFFFE] = 8'($urandom);
      mem[16'hFFFF] = 8'($urandom);
      exp_int(2'b11, pc, sp, p);
      sif.pc_in = pc; sif.sp_in = sp; sif.status_in = p;
      sif.i_flag = 1'b0; sif.irq = 1'b1; sif.instr_boundary = 1'b1;
      st = log_q.size();
      tick(1);
      sif.instr_boundary = 1'b0; sif.irq = 1'b0;
      tick(2);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (now_c !== rs) begin
         n_fail++; $display("FAIL abort_reset_outputs got %h exp %h", now_c, rs);
      end
      tick(1);
      n_checks++;
      if (log_q.size() - st != 2) begin
         n_fail++; $display("FAIL abort_partial_len got %0d exp 2", log_q.size() - st);
      end
      for (int i = 0; i < 2; i++) begin
         got = (st + i < log_q.size()) ? log_q[st + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL abort_partial[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
      mem[16'hFFFC] = 8'($urandom);
      mem[16'hFFFD] = 8'($urandom);
      st2 = log_q.size();
      rst_n = 1'b1;
      tick(6);
      exp_reset();
      n_checks++;
      if (log_q.size() - st2 != exp_q.size()) begin
         n_fail++; $display("FAIL abort_refetch_len got %0d exp %0d", log_q.size() - st2, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (st2 + i < log_q.size()) ? log_q[st2 + i] : '0;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_fail++; $display("FAIL abort_refetch[%0d] got %h exp %h", i, got, exp_q[i]);
         end
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      sif.clk_enable     = 1'b1;
      sif.irq            = 1'b0;
      sif.nmi            = 1'b0;
      sif.i_flag         = 1'b0;
      sif.instr_boundary = 1'b0;
      sif.pc_in          = 16'h0000;
      sif.sp_in          = 8'h00;
      sif.status_in      = 8'h00;
      test_reset();
      test_irq_basic();
      test_irq_random();
      test_irq_masked();
      test_nmi_priority();
      test_sp_wrap();
      test_clk_enable_freeze();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences the CPU datapath for reset, NMI and IRQ entry.
- On reset it fetches the reset vector and loads the PC.
- On an accepted interrupt it pushes PCH, PCL and P to the stack page, fetches the vector, loads the PC and sets the I flag.
- Sits beside instruction_decode. While busy it owns the address bus, rw, the data-out path, the SP decrement and the PC load, and instruction_decode must hold in its idle state.

Parameters:
- NMI_VECTOR, 16'hFFFA, address of the NMI vector low byte.
- RESET_VECTOR, 16'hFFFC, address of the reset vector low byte.
- IRQ_VECTOR, 16'hFFFE, address of the IRQ vector low byte.
- STACK_PAGE, 8'h01, high byte of every stack address.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clk_enable  input  1  state and registers advance only when high.
- irq  input  1  level-sensitive interrupt request, active-high.
- nmi  input  1  non-maskable request, active-high; only its rising edge counts.
- i_flag  input  1  interrupt-disable bit from the processor status register.
- instr_boundary  input  1  high when instruction_decode is at an opcode-fetch boundary.
- pc_in  input  16  current program counter.
- sp_in  input  8  current stack pointer.
- status_in  input  8  current processor status.
- data_in  input  8  data bus read value.
- busy  output  1  sequencer owns the bus; decode stalls.
- address  output  16  bus address while busy.
- rw  output  1  1 = read, 0 = write.
- data_out  output  8  write data.
- sp_dec  output  1  one-cycle pulse: stack pointer decrements by 1.
- pc_load  output  1  one-cycle pulse: PC <= pc_value.
- pc_value  output  16  vector loaded into the PC.
- set_i  output  1  one-cycle pulse: set the I flag.
- source  output  2  sequence in progress: 00 none, 01 reset, 10 NMI, 11 IRQ.

Behaviour:
- Moore outputs decoded from state and internal registers.
- States: S_RST, S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_LOAD_PC.
- All transitions and register updates happen only on clk rising edges with clk_enable=1. With clk_enable=0, state, registers and outputs are frozen.
- While rst_n=0:
  - state=S_RST, nmi_pending=0, nmi_prev=0, source=01.
  - busy=1, rw=1, address=0, data_out=0, sp_dec=0, pc_load=0, set_i=0, pc_value=0.
- Asserting rst_n mid-sequence aborts the sequence immediately; partial pushes are not completed.
- NMI edge detection:
  - nmi_prev <= nmi on every enabled cycle.
  - nmi & ~nmi_prev sets nmi_pending.
  - Entering S_PUSH_PCH with source=NMI clears nmi_pending; a new edge in that same cycle re-sets it (set wins).
  - An NMI edge during any sequence stays pending.
- S_RST -> S_VEC_LO with vec_base=RESET_VECTOR. There are no stack pushes and no sp_dec on reset.
- S_IDLE:
  - busy=0.
  - If instr_boundary is high and nmi_pending is set: source=10, vec_base=NMI_VECTOR.
  - Otherwise, if instr_boundary is high, irq=1 and i_flag=0: source=11, vec_base=IRQ_VECTOR.
  - On either, latch sp_lat<=sp_in, pc_lat<=pc_in, p_lat<=status_in, then go to S_PUSH_PCH.
  - NMI has priority over IRQ.
- Push states (rw=0, sp_dec=1, one cycle each):
  - S_PUSH_PCH: address={STACK_PAGE,sp_lat}, data_out=pc_lat[15:8].
  - S_PUSH_PCL: address={STACK_PAGE,sp_lat-1}, data_out=pc_lat[7:0].
  - S_PUSH_P: address={STACK_PAGE,sp_lat-2}, data_out=(p_lat|8'h20)&~8'h10.
  - SP arithmetic is 8-bit modulo and wraps inside the stack page (00 -> FF).
- S_VEC_LO: rw=1, address=vec_base; sample vec_lo<=data_in at the end of the cycle.
- S_VEC_HI: rw=1, address=vec_base+1; sample vec_hi<=data_in.
- S_LOAD_PC:
  - pc_load=1, pc_value={vec_hi,vec_lo}, rw=1, address=0.
  - set_i=1, also after reset.
  - Next state S_IDLE, source cleared to 00.
- Latency:
  - Reset: 3 enabled cycles after release before busy falls.
  - Interrupt: 6 enabled busy cycles.
- irq is not latched. If irq drops before a boundary, nothing is taken.
- After an interrupt, set_i makes i_flag=1, so a still-high irq is not retaken.

Test Plan:
- Reset, memory FFFC=00, FFFD=80: release rst_n -> reads FFFC then FFFD, pc_load with pc_value=8000, set_i=1, busy=0 after 3 enabled cycles, no sp_dec.
- IRQ with i_flag=0, pc_in=1234, sp_in=FD, status_in=31, boundary=1, FFFE/FFFF=00/90:
  - writes 12@01FD, 34@01FC, 21@01FB with 3 sp_dec pulses;
  - then pc_value=9000, set_i=1, source=11 throughout.
- IRQ held with i_flag=1 across boundaries -> busy stays 0, no bus writes.
- nmi and irq rise in the same cycle at a boundary -> vector FFFA used, source=10; nmi held high afterwards -> no second NMI; a later nmi low->high pulse is taken at the next boundary.
- sp_in=01 with an NMI -> pushes to 0101, 0100, 01FF.
- Mid-sequence events:
  - clk_enable held low 3 cycles in S_PUSH_PCL -> outputs unchanged, same address.
  - rst_n pulsed low during S_PUSH_P -> busy=1, rw=1 at once; after release only the FFFC/FFFD fetch occurs.
